ixc_fifo_5: RTL
===============

# ixc_fifo_5

Five-bit, first-word-fall-through valid/ready FIFO that drives the 5-bit `R` input of the downstream 5-bit assign stage in the emulation template library. It decouples a bursty 5-bit producer from the assign stage's consumer with a parameterised number of entries. It also reports occupancy and a high-water mark for emulation debug. The output data is always a registered storage word, with no combinational path from `in_data` to `out_data`.

## Interface
- `WIDTH`, 5, data width; fixed at 5 for this template and must not be overridden.
- `DEPTH`, 4, number of entries; a power of two, minimum 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `flush`  in  1  synchronous clear of contents, `count` and `hwm`.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO can accept; a registered signal, equal to `count != DEPTH`.
- `in_data`  in  WIDTH  producer word.
- `out_valid`  out  1  head word is present; a registered signal, equal to `count != 0`.
- `out_ready`  in  1  consumer takes the head word.
- `out_data`  out  WIDTH  head word; feeds the assign stage's `R` input.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `hwm`  out  $clog2(DEPTH)+1  maximum `count` seen since reset or flush.

## Operation
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Storage is DEPTH×WIDTH registers. There is a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH.
- On push: write `in_data` to `mem[wptr]`, then advance `wptr`.
- On pop: advance `rptr`. `out_data` = `mem[rptr]`, selected by the registered pointer.
- `count` update rules:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal at any occupancy from 1 to DEPTH−1.
- Full (`count == DEPTH`): `in_ready` = 0 and no push is possible. A pop in that cycle makes `in_ready` = 1 on the next cycle.
- Empty (`count == 0`): `out_valid` = 0 and a pop is impossible. `out_ready` is ignored.
- Empty-cycle push: `out_valid` rises on the next cycle. There is no same-cycle bypass.
- `hwm` is updated each cycle to max(`hwm`, next `count`) and saturates at DEPTH.
- `flush` behaviour:
  - Pointers, `count` and `hwm` go to 0 on the next edge.
  - A push or pop in the flush cycle is discarded, so flush wins.
  - Storage contents are not cleared.
- Reset (`rst_n` low, at any time, including mid-burst) forces these values asynchronously:
  - `wptr` = `rptr` = 0, `count` = 0, `hwm` = 0.
  - `out_valid` = 0, `in_ready` = 1.
- `out_data` is undefined while `out_valid` = 0. Storage is not reset.
- `out_data` must stay stable while `out_valid & !out_ready`.

## Timing
- Latency from push to the word being visible at `out_data`/`out_valid`: 1 cycle.
- Throughput: 1 word per cycle sustained when `out_ready` is held high.
- `in_ready`, `out_valid`, `count` and `hwm` are all flop outputs, with no combinational input-to-output paths.
- Reset deassertion is synchronised outside this block. The first push can be accepted on the first rising edge with `rst_n` high.

## Structure
- Shared package `ixc_fifo_pkg` holds:
  - `IXC_W5` = 5.
  - A `ptr_t` typedef derived from DEPTH.
  - A `cnt_t` typedef for `count`/`hwm`.
- Sub-module `ixc_fifo_ptr` is a wrapping pointer register with parameter DEPTH, and ports `clk`, `rst_n`, `clr`, `inc` and `ptr`. It is instantiated twice, once for write and once for read.
- The top-level module holds storage, `count`, `hwm` and the flag registers.

## Test plan
- Reset then idle: `in_ready` = 1, `out_valid` = 0, `count` = 0 and `hwm` = 0, with reset asserted mid-stream too.
- Push 5'h01..5'h04 with `out_ready` = 0:
  - `count` steps 1..4 and `in_ready` = 0 after the 4th push.
  - A 5th `in_valid` (5'h05) is not accepted.
  - `hwm` = 4.
- Drain from full with `out_ready` = 1: `out_data` is 01, 02, 03, 04 on consecutive cycles, then `out_valid` = 0 and `count` = 0. `hwm` stays 4.
- Simultaneous push and pop at `count` = 2 for 10 cycles with an incrementing pattern: `count` holds at 2, order is preserved, and pointers wrap at least twice.
- Push 5'h1F while empty: `out_valid` = 0 in the same cycle, then 1 on the next cycle with `out_data` = 5'h1F.
- `flush` asserted with `count` = 3 and `in_valid` = 1: on the next cycle `count` = 0, `hwm` = 0 and `out_valid` = 0, and the flush-cycle word is absent.

Source files
------------

// File: rtl/ixc_fifo_pkg.sv
// Shared constants and types for the 5-bit emulation FIFO family.
package ixc_fifo_pkg;

  localparam int unsigned IXC_W5    = 5;
  localparam int unsigned IXC_DEPTH = 4;
  localparam int unsigned IXC_PW    = $clog2(IXC_DEPTH);
  localparam int unsigned IXC_CW    = IXC_PW + 1;

  typedef logic [IXC_PW-1:0] ptr_t;
  typedef logic [IXC_CW-1:0] cnt_t;
  typedef logic [IXC_W5-1:0] word_t;

endpackage

// File: rtl/ixc_fifo_ptr.sv
// Wrapping modulo-DEPTH pointer register with synchronous clear.
module ixc_fifo_ptr
  import ixc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = IXC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned PW = $clog2(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ixc_fifo_5.sv
// First-word-fall-through valid/ready FIFO feeding the 5-bit assign stage,
// with occupancy and high-water-mark reporting.
module ixc_fifo_5
  import ixc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = IXC_W5,
  parameter int unsigned DEPTH = IXC_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] hwm
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic             push;
  logic             pop;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    hwm_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  // Flush discards any handshake in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  ixc_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wptr)
  );

  ixc_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rptr)
  );

  // Next occupancy and high-water mark; hwm is naturally bounded by DEPTH.
  always_comb begin
    count_nxt = count;
    hwm_nxt   = hwm;
    if (flush) begin
      count_nxt = '0;
      hwm_nxt   = '0;
    end else begin
      if (push && !pop) begin
        count_nxt = count + CW'(1);
      end else if (pop && !push) begin
        count_nxt = count - CW'(1);
      end
      if (count_nxt > hwm) begin
        hwm_nxt = count_nxt;
      end
    end
  end

  // Flags are registered copies of the next-occupancy decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      hwm       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      count     <= count_nxt;
      hwm       <= hwm_nxt;
      in_ready  <= (count_nxt != CW'(DEPTH));
      out_valid <= (count_nxt != '0);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  assign out_data = mem[rptr];

endmodule
